// File: rtl/wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pipe_reg
// Description : Multi-lane MEM->WB pipeline register with stall tap, flush,
//               x0 write suppression, same-cycle lane-conflict resolution and
//               a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pipe_reg #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int STAGE  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                stall,
  input  logic                      flush,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic                      wb_valid,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [LANES*ADDR_W-1:0] r_wd;
  logic [LANES-1:0]        r_wreg;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic                    r_valid;
  logic [CNT_W-1:0]        r_cnt;

  logic [LANES-1:0]        w_wreg_eff;
  logic [LANES-1:0]        w_wreg_cap;
  logic                    w_stall_here;
  logic                    w_stall_next;
  logic                    w_bubble;
  logic                    w_unused_stall;

  assign w_stall_here   = stall[STAGE];
  assign w_stall_next   = stall[STAGE+1];
  // Downstream still moving while we stop: a bubble must be inserted.
  assign w_bubble       = flush | (w_stall_here & ~w_stall_next);
  // Only two bits of the stall vector matter to this stage.
  assign w_unused_stall = ^stall;

  // Per-lane effective write enable: drop writes that target x0.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_eff
      assign w_wreg_eff[gi] = mem_wreg[gi] & (mem_wd[gi*ADDR_W +: ADDR_W] != '0);
    end
  endgenerate

  // Conflict resolution: a lower lane loses to any higher lane writing the same register.
  always_comb begin
    w_wreg_cap = w_wreg_eff;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wreg_eff[i] && w_wreg_eff[j] &&
            (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W])) begin
          w_wreg_cap[i] = 1'b0;
        end
      end
    end
  end

  // Pipeline register: reset > flush/bubble > load > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd    <= '0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_bubble) begin
      r_wd    <= '0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
      if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (!w_stall_here) begin
      r_wd    <= mem_wd;
      r_wreg  <= w_wreg_cap;
      r_wdata <= mem_wdata;
      r_valid <= 1'b1;
    end
  end

  assign wb_wd      = r_wd;
  assign wb_wreg    = r_wreg;
  assign wb_wdata   = r_wdata;
  assign wb_valid   = r_valid;
  assign bubble_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_pipe_reg
// Description : Directed self-checking bench for wb_pipe_reg (default widths
//               plus a CNT_W=2 instance for counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [9:0]  mem_wd;
  logic [1:0]  mem_wreg;
  logic [63:0] mem_wdata;

  logic [9:0]  wb_wd,    s_wd;
  logic [1:0]  wb_wreg,  s_wreg;
  logic [63:0] wb_wdata, s_wdata;
  logic        wb_valid, s_valid;
  logic [15:0] bubble_cnt;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_valid(wb_valid), .bubble_cnt(bubble_cnt)
  );

  wb_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
    .wb_valid(s_valid), .bubble_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] wd, input logic [1:0] wr,
                         input logic [63:0] wdat, input logic v, input logic [15:0] cnt);
    chk({tag, ".wd"},    64'(wb_wd),      64'(wd));
    chk({tag, ".wreg"},  64'(wb_wreg),    64'(wr));
    chk({tag, ".wdata"}, wb_wdata,        wdat);
    chk({tag, ".valid"}, 64'(wb_valid),   64'(v));
    chk({tag, ".cnt"},   64'(bubble_cnt), 64'(cnt));
  endtask

  initial begin
    // Reset held for two edges with busy inputs.
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    mem_wd = {5'd3, 5'd5}; mem_wreg = 2'b11; mem_wdata = {32'h1234, 32'h5678};
    tick();
    chk_all("rst1", '0, '0, '0, 1'b0, 16'd0);
    tick();
    chk_all("rst2", '0, '0, '0, 1'b0, 16'd0);
    chk("rst2.satcnt", 64'(s_cnt), 64'd0);

    // Load with lane1 targeting x0.
    rst = 1'b0;
    mem_wd = {5'd0, 5'd5}; mem_wreg = 2'b11; mem_wdata = {32'h1, 32'hDEADBEEF};
    tick();
    chk_all("load_x0", {5'd0, 5'd5}, 2'b01, {32'h1, 32'hDEADBEEF}, 1'b1, 16'd0);

    // Same-destination conflict: lane1 wins.
    mem_wd = {5'd7, 5'd7}; mem_wreg = 2'b11; mem_wdata = {32'hB, 32'hA};
    tick();
    chk_all("conflict", {5'd7, 5'd7}, 2'b10, {32'hB, 32'hA}, 1'b1, 16'd0);

    // Conflict only among effective writes: lane1 disabled, lane0 keeps write.
    mem_wd = {5'd7, 5'd7}; mem_wreg = 2'b01; mem_wdata = {32'hB, 32'hA};
    tick();
    chk("noconf.wreg", 64'(wb_wreg), 64'(2'b01));

    // Distinct addresses, irrelevant stall bits set.
    stall = 6'b001111;
    mem_wd = {5'd9, 5'd4}; mem_wreg = 2'b11; mem_wdata = {32'hC, 32'hD};
    tick();
    chk_all("load2", {5'd9, 5'd4}, 2'b11, {32'hC, 32'hD}, 1'b1, 16'd0);

    // Hold a real entry while inputs change.
    stall = 6'b110000;
    mem_wd = {5'd1, 5'd2}; mem_wreg = 2'b11; mem_wdata = {32'hE, 32'hF};
    tick();
    tick();
    chk_all("hold_entry", {5'd9, 5'd4}, 2'b11, {32'hC, 32'hD}, 1'b1, 16'd0);

    // Bubble then hold the bubble for three cycles.
    stall = 6'b010000;
    tick();
    chk_all("bubble", '0, '0, '0, 1'b0, 16'd1);
    stall = 6'b110000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("hold_bubble", '0, '0, '0, 1'b0, 16'd1);
    end

    // Flush overrides hold.
    stall = 6'b000000;
    mem_wd = {5'd0, 5'd3}; mem_wreg = 2'b01; mem_wdata = {32'h0, 32'h33};
    tick();
    chk_all("load3", {5'd0, 5'd3}, 2'b01, {32'h0, 32'h33}, 1'b1, 16'd1);
    flush = 1'b1; stall = 6'b110000;
    tick();
    chk_all("flush_hold", '0, '0, '0, 1'b0, 16'd2);
    chk("flush.satcnt", 64'(s_cnt), 64'd2);
    flush = 1'b0;

    // Saturation on the CNT_W=2 instance from a fresh reset.
    rst = 1'b1;
    tick();
    chk("sat_rst.cnt", 64'(bubble_cnt), 64'd0);
    chk("sat_rst.satcnt", 64'(s_cnt), 64'd0);
    rst = 1'b0; stall = 6'b010000;
    tick(); chk("sat1", 64'(s_cnt), 64'd1);
    tick(); chk("sat2", 64'(s_cnt), 64'd2);
    tick(); chk("sat3", 64'(s_cnt), 64'd3);
    tick(); chk("sat4", 64'(s_cnt), 64'd3);
    tick(); chk("sat5", 64'(s_cnt), 64'd3);
    chk("sat5.widecnt", 64'(bubble_cnt), 64'd5);

    // Flush and bubble on the same edge count once.
    flush = 1'b1;
    tick();
    chk("flush_bubble.cnt", 64'(bubble_cnt), 64'd6);
    flush = 1'b0;

    // Mid-hold reset: two bubbles, load, hold, then reset.
    rst = 1'b1; stall = 6'b0;
    tick();
    rst = 1'b0; stall = 6'b010000;
    tick();
    tick();
    stall = 6'b000000;
    mem_wd = {5'd1, 5'd2}; mem_wreg = 2'b11; mem_wdata = {32'hE, 32'hF};
    tick();
    stall = 6'b110000;
    tick();
    chk_all("prehold", {5'd1, 5'd2}, 2'b11, {32'hE, 32'hF}, 1'b1, 16'd2);
    rst = 1'b1;
    tick();
    chk_all("midhold_rst", '0, '0, '0, 1'b0, 16'd0);
    rst = 1'b0; stall = 6'b000000;
    mem_wd = {5'd6, 5'd8}; mem_wreg = 2'b11; mem_wdata = {32'h11, 32'h22};
    tick();
    chk_all("post_rst_load", {5'd6, 5'd8}, 2'b11, {32'h11, 32'h22}, 1'b1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
